// File: rtl/vca_adsr.sv
`default_nettype none
// ============================================================================
// Module      : vca_adsr
// Description : Voltage-controlled amplifier with an ADSR envelope generator.
//               The audio sample from the VCF is multiplied by a 16-bit
//               envelope. The envelope advances one step per sample tick,
//               which is the rising edge of sample_clk.
//
// Ports       : clk          system clock, all state on posedge
//               reset_n      asynchronous active-low reset
//               sample_clk   sample-rate square wave; rising edge = new sample
//               gate         note gate, 1 = key held
//               attack       attack step, inc = attack+1 per tick
//               decay        decay step,  dec = decay+1 per tick
//               sustain      sustain level, S = sustain << (DATA_W-RATE_W)
//               release_rate release step, rel = release_rate+1 per tick
//                            ('release' is a reserved word)
//               sig_in       unsigned audio in
//               sig_out      unsigned amplified audio, registered
//               env_out      current envelope value, registered
//               env_active   1 while the envelope is not idle
//
// Options     : ADSR_EXP_DECAY_EN - exponential-style decay/release steps
//               proportional to the remaining distance to the target.
//
// Revision    : 1.0 - initial release
// ============================================================================
module vca_adsr #(
    parameter int DATA_W = 16,
    parameter int RATE_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_clk,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack,
    input  logic [RATE_W-1:0] decay,
    input  logic [RATE_W-1:0] sustain,
    input  logic [RATE_W-1:0] release_rate,
    input  logic [DATA_W-1:0] sig_in,
    output logic [DATA_W-1:0] sig_out,
    output logic [DATA_W-1:0] env_out,
    output logic              env_active
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [DATA_W:0] c_ONE  = {{DATA_W{1'b0}}, 1'b1};
    localparam logic [DATA_W:0] c_FULL = {1'b0, {DATA_W{1'b1}}};

    state_t              r_state;
    logic [DATA_W-1:0]   r_env;
    logic [DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]   r_sig_out;
    logic                r_gate_q;
    logic                r_sample_clk_q;

    logic                w_tick;
    logic [DATA_W-1:0]   w_s;
    logic [DATA_W:0]     w_env_e;
    logic [DATA_W:0]     w_inc;
    logic [DATA_W:0]     w_dec;
    logic [DATA_W:0]     w_rel;
    logic [DATA_W:0]     w_att_sum;
    logic                w_att_sat;
    logic [DATA_W-1:0]   w_att_env;
    logic [DATA_W-1:0]   w_rel_base;
    logic [DATA_W:0]     w_rel_diff;
    logic                w_rel_done;
    logic [DATA_W-1:0]   w_rel_env;
    state_t              w_rel_state;
    logic [DATA_W:0]     w_dec_diff;
    logic                w_dec_done;
    logic [2*DATA_W-1:0] w_prod;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_env_nxt;
    logic                w_unused;

    assign w_tick  = sample_clk & ~r_sample_clk_q;
    assign w_s     = {sustain, {(DATA_W-RATE_W){1'b0}}};
    assign w_env_e = {1'b0, r_env};
    assign w_inc   = {{(DATA_W+1-RATE_W){1'b0}}, attack} + c_ONE;

    // Attack step, saturated at full scale.
    assign w_att_sum = w_env_e + w_inc;
    assign w_att_sat = (w_att_sum >= c_FULL);
    assign w_att_env = w_att_sat ? c_FULL[DATA_W-1:0] : w_att_sum[DATA_W-1:0];

    // A gate release in ATTACK steps down from the attack result, so a note
    // released on the peak tick starts its release from full scale.
    assign w_rel_base = (r_state == ST_ATTACK) ? w_att_env : r_env;

`ifdef ADSR_EXP_DECAY_EN
    logic [DATA_W-1:0]        w_exp_dist;
    logic [RATE_W:0]          w_dec_k;
    logic [RATE_W:0]          w_rel_k;
    logic [DATA_W+RATE_W:0]   w_dec_prod;
    logic [DATA_W+RATE_W:0]   w_rel_prod;
    logic                     w_unused_exp;

    // Distance above sustain; zero when sustain was raised above env.
    assign w_exp_dist = (r_env > w_s) ? (r_env - w_s) : '0;
    assign w_dec_k    = {1'b0, decay} + {{RATE_W{1'b0}}, 1'b1};
    assign w_rel_k    = {1'b0, release_rate} + {{RATE_W{1'b0}}, 1'b1};
    assign w_dec_prod = {{(RATE_W+1){1'b0}}, w_exp_dist} * {{DATA_W{1'b0}}, w_dec_k};
    assign w_rel_prod = {{(RATE_W+1){1'b0}}, w_rel_base} * {{DATA_W{1'b0}}, w_rel_k};
    // Minimum step of 1 guarantees the terminal condition is always reached.
    assign w_dec = (w_dec_prod[DATA_W+RATE_W:RATE_W] == '0) ? c_ONE
                                                           : w_dec_prod[DATA_W+RATE_W:RATE_W];
    assign w_rel = (w_rel_prod[DATA_W+RATE_W:RATE_W] == '0) ? c_ONE
                                                           : w_rel_prod[DATA_W+RATE_W:RATE_W];
    assign w_unused_exp = ^{w_dec_prod[RATE_W-1:0], w_rel_prod[RATE_W-1:0]};
`else
    assign w_dec = {{(DATA_W+1-RATE_W){1'b0}}, decay} + c_ONE;
    assign w_rel = {{(DATA_W+1-RATE_W){1'b0}}, release_rate} + c_ONE;
`endif

    // Release step; the "<=" test keeps the subtraction from underflowing.
    assign w_rel_diff  = {1'b0, w_rel_base} - w_rel;
    assign w_rel_done  = ({1'b0, w_rel_base} <= w_rel);
    assign w_rel_env   = w_rel_done ? '0 : w_rel_diff[DATA_W-1:0];
    assign w_rel_state = w_rel_done ? ST_IDLE : ST_RELEASE;

    // Decay step; also snaps env up to a sustain that was raised above it.
    assign w_dec_diff = w_env_e - w_dec;
    assign w_dec_done = (w_env_e <= ({1'b0, w_s} + w_dec));

    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        case (r_state)
            ST_IDLE: begin
                w_env_nxt = '0;
                if (gate) begin
                    w_state_nxt = ST_ATTACK;
                    w_env_nxt   = w_inc[DATA_W-1:0];
                end
            end
            ST_ATTACK: begin
                if (!gate) begin
                    w_state_nxt = w_rel_state;
                    w_env_nxt   = w_rel_env;
                end else begin
                    w_state_nxt = w_att_sat ? ST_DECAY : ST_ATTACK;
                    w_env_nxt   = w_att_env;
                end
            end
            ST_DECAY: begin
                if (!gate) begin
                    w_state_nxt = w_rel_state;
                    w_env_nxt   = w_rel_env;
                end else if (w_dec_done) begin
                    w_state_nxt = ST_SUSTAIN;
                    w_env_nxt   = w_s;
                end else begin
                    w_env_nxt   = w_dec_diff[DATA_W-1:0];
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    w_state_nxt = w_rel_state;
                    w_env_nxt   = w_rel_env;
                end else begin
                    w_env_nxt   = w_s;
                end
            end
            ST_RELEASE: begin
                // Retrigger continues from the current level.
                if (gate && !r_gate_q) begin
                    w_state_nxt = w_att_sat ? ST_DECAY : ST_ATTACK;
                    w_env_nxt   = w_att_env;
                end else begin
                    w_state_nxt = w_rel_state;
                    w_env_nxt   = w_rel_env;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_env_nxt   = '0;
            end
        endcase
    end

    assign w_prod   = {{DATA_W{1'b0}}, r_x} * {{DATA_W{1'b0}}, r_env};
    assign w_unused = ^{w_prod[DATA_W-1:0], w_dec_diff[DATA_W], w_rel_diff[DATA_W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_env          <= '0;
            r_x            <= '0;
            r_gate_q       <= 1'b0;
            r_sample_clk_q <= 1'b0;
            r_sig_out      <= '0;
        end else begin
            r_sample_clk_q <= sample_clk;
            // Product of the values latched on the previous tick.
            r_sig_out      <= w_prod[2*DATA_W-1:DATA_W];
            if (w_tick) begin
                r_x      <= sig_in;
                r_gate_q <= gate;
                r_state  <= w_state_nxt;
                r_env    <= w_env_nxt;
            end
        end
    end

    assign sig_out    = r_sig_out;
    assign env_out    = r_env;
    assign env_active = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vca_adsr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vca_adsr
// Description : Directed bench for vca_adsr covering reset, attack, decay,
//               sustain tracking, release, retrigger and frozen sample clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vca_adsr;

    logic        clk;
    logic        reset_n;
    logic        sample_clk;
    logic        gate;
    logic [9:0]  attack;
    logic [9:0]  decay;
    logic [9:0]  sustain;
    logic [9:0]  release_rate;
    logic [15:0] sig_in;
    logic [15:0] sig_out;
    logic [15:0] env_out;
    logic        env_active;

    int n_checks = 0;
    int n_pass   = 0;

    vca_adsr #(.DATA_W(16), .RATE_W(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_clk   (sample_clk),
        .gate         (gate),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .release_rate (release_rate),
        .sig_in       (sig_in),
        .sig_out      (sig_out),
        .env_out      (env_out),
        .env_active   (env_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One sample tick = sample_clk high for one clk, then low for one clk.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sample_clk = 1'b1;
            @(negedge clk) sample_clk = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        sample_clk   = 1'b0;
        gate         = 1'b1;
        attack       = 10'd1023;
        decay        = 10'd255;
        sustain      = 10'd512;
        release_rate = 10'd0;
        sig_in       = 16'h8000;

        // Reset held while gate is high and ticks run.
        tick_n(5);
        check("rst_env",    env_out,    32'h0);
        check("rst_sig",    sig_out,    32'h0);
        check("rst_active", env_active, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        // Attack at inc=1024.
        tick_n(1);
        check("att_t1",     env_out,    32'h0400);
        check("att_active", env_active, 32'h1);
        tick_n(1);
        check("att_t2",     env_out,    32'h0800);
        tick_n(61);
        check("att_t63",    env_out,    32'hFC00);
        tick_n(1);
        check("att_t64",    env_out,    32'hFFFF);
        @(negedge clk);
        check("att_sig",    sig_out,    32'h7FFF);

        // Decay at dec=256 down to S=0x8000.
        tick_n(1);
        check("dec_t1",     env_out,    32'hFEFF);
        tick_n(126);
        check("dec_t127",   env_out,    32'h80FF);
        tick_n(1);
        check("dec_t128",   env_out,    32'h8000);
        sustain = 10'd256;
        sig_in  = 16'hFFFF;
        tick_n(1);
        check("sus_track",  env_out,    32'h4000);
        @(negedge clk);
        check("sus_sig",    sig_out,    32'h3FFF);

        // Release at rel=1 from 0x4000.
        gate = 1'b0;
        tick_n(1);
        check("rel_t1",     env_out,    32'h3FFF);
        tick_n(16382);
        check("rel_t16383", env_out,    32'h0001);
        check("rel_active", env_active, 32'h1);
        tick_n(1);
        check("rel_t16384", env_out,    32'h0000);
        check("idle_active", env_active, 32'h0);
        tick_n(1);
        check("idle_hold",  env_out,    32'h0000);

        // Retrigger during release continues from current env.
        gate    = 1'b1;
        attack  = 10'd1023;
        decay   = 10'd1023;
        sustain = 10'd129;     // S = 0x2040
        tick_n(64);
        check("rt_peak",    env_out,    32'hFFFF);
        tick_n(70);
        check("rt_sustain", env_out,    32'h2040);
        gate         = 1'b0;
        release_rate = 10'd63; // rel = 64
        tick_n(1);
        check("rt_rel",     env_out,    32'h2000);
        gate   = 1'b1;
        attack = 10'd0;
        tick_n(1);
        check("rt_attack",  env_out,    32'h2001);

        // Asynchronous reset mid-attack, checked before any clk edge.
        #1 reset_n = 1'b0;
        #1;
        check("arst_env",    env_out,    32'h0);
        check("arst_sig",    sig_out,    32'h0);
        check("arst_active", env_active, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        // Gate falls on the tick that attack reaches full scale.
        gate         = 1'b1;
        attack       = 10'd1023;
        release_rate = 10'd0;
        sig_in       = 16'h8000;
        tick_n(63);
        check("gf_t63",     env_out,    32'hFC00);
        gate = 1'b0;
        tick_n(1);
        check("gf_rel",     env_out,    32'hFFFE);
        @(negedge clk);
        check("gf_sig",     sig_out,    32'h7FFF);

        // sample_clk rises once then is held high: one tick, then frozen.
        @(negedge clk) sample_clk = 1'b1;
        @(negedge clk) sig_in = 16'h1234;
        repeat (100) @(negedge clk);
        check("hold_env",   env_out,    32'hFFFD);
        check("hold_sig",   sig_out,    32'h7FFE);
        sample_clk = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
